data_mem_if: RTL and testbench



---
 rtl/mem_pkg.sv | 17 +
 rtl/data_mem_if_load_extend.sv | 30 +++
 rtl/data_mem_if.sv | 150 +++++++++++++++
 tb/tb_data_mem_if.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data-side load/store unit: bus size codes,
// FSM state encodings and the default datapath width.
package mem_pkg;

   localparam int DATA_W = 32;

   localparam logic [1:0] SIZE_WORD = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_BYTE = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUS  = 2'b01,
      TRAP = 2'b10
   } mem_state_e;

endpackage

// File: rtl/data_mem_if_load_extend.sv
// Combinational load-data extension: picks the low lane of the raw bus word
// and sign- or zero-extends it according to the access size.
module load_extend
   import mem_pkg::*;
#(
   parameter int DATA_W = mem_pkg::DATA_W
) (
   input  logic [1:0]        i_size,
   input  logic              i_unsigned,
   input  logic [DATA_W-1:0] i_raw,
   output logic [DATA_W-1:0] o_data
);

   logic w_half_sign;
   logic w_byte_sign;

   assign w_half_sign = i_raw[15] & ~i_unsigned;
   assign w_byte_sign = i_raw[7]  & ~i_unsigned;

   // Size 11 falls into the default arm and behaves as a byte.
   always_comb begin
      o_data = i_raw;
      case (i_size)
         SIZE_WORD: o_data = i_raw;
         SIZE_HALF: o_data = {{(DATA_W-16){w_half_sign}}, i_raw[15:0]};
         default:   o_data = {{(DATA_W-8){w_byte_sign}}, i_raw[7:0]};
      endcase
   end

endmodule

// File: rtl/data_mem_if.sv
// Load/store unit between the MEM stage and the external data bus.
// Optional: define MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module data_mem_if
   import mem_pkg::*;
#(
   parameter int DATA_W = mem_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [DATA_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              misalign,
   output logic [DATA_W-1:0] DAD,
   inout  wire  [DATA_W-1:0] DDT,
   output logic              MREQ,
   output logic              WRITE,
   output logic [1:0]        SIZE,
   input  logic              ACKD_n,
   output mem_state_e        o_dbg_state
);

   // Request handshake: a request transfers on a posedge where
   // req_valid && req_ready; req_ready is high exactly in IDLE.

   mem_state_e        r_state;
   mem_state_e        w_state_nxt;

   logic [DATA_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [1:0]        r_size;
   logic              r_write;
   logic              r_unsigned;
   logic              r_resp_valid;
   logic [DATA_W-1:0] r_resp_rdata;

   logic [DATA_W-1:0] w_wdata_fmt;
   logic [DATA_W-1:0] w_load_ext;
   logic              w_accept;
   logic              w_ack;
   logic              w_misaligned;

   assign w_accept = (r_state == IDLE) && req_valid;
   assign w_ack    = (r_state == BUS) && !ACKD_n;

`ifdef MEM_MISALIGN_TRAP_EN
   logic r_misalign;

   assign w_misaligned = ((req_size == SIZE_HALF) && req_addr[0]) ||
                         ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));
   assign misalign     = r_misalign;
`else
   assign w_misaligned = 1'b0;
   assign misalign     = 1'b0;
`endif

   // Sub-word store data is right-aligned into the low lanes.
   always_comb begin
      w_wdata_fmt = req_wdata;
      case (req_size)
         SIZE_WORD: w_wdata_fmt = req_wdata;
         SIZE_HALF: w_wdata_fmt = {{(DATA_W-16){1'b0}}, req_wdata[15:0]};
         default:   w_wdata_fmt = {{(DATA_W-8){1'b0}}, req_wdata[7:0]};
      endcase
   end

   load_extend #(.DATA_W(DATA_W)) u_load_extend (
      .i_size     (r_size),
      .i_unsigned (r_unsigned),
      .i_raw      (DDT),
      .o_data     (w_load_ext)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (req_valid) w_state_nxt = w_misaligned ? TRAP : BUS;
         end
         BUS: begin
            if (!ACKD_n) w_state_nxt = IDLE;
         end
`ifdef MEM_MISALIGN_TRAP_EN
         TRAP:    w_state_nxt = IDLE;
`endif
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr       <= '0;
         r_wdata      <= '0;
         r_size       <= SIZE_WORD;
         r_write      <= 1'b0;
         r_unsigned   <= 1'b0;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= '0;
      end else begin
         r_resp_valid <= 1'b0;
         if (w_accept) begin
            r_addr     <= req_addr;
            r_wdata    <= w_wdata_fmt;
            r_size     <= req_size;
            r_write    <= req_write;
            r_unsigned <= req_unsigned;
         end
         if (w_ack) begin
            r_resp_valid <= 1'b1;
            r_resp_rdata <= r_write ? '0 : w_load_ext;
         end
         if (r_state == TRAP) begin
            r_resp_valid <= 1'b1;
            r_resp_rdata <= '0;
         end
      end
   end

`ifdef MEM_MISALIGN_TRAP_EN
   always_ff @(posedge clk) begin
      if (rst)                  r_misalign <= 1'b0;
      else if (w_ack)           r_misalign <= 1'b0;
      else if (r_state == TRAP) r_misalign <= 1'b1;
   end
`endif

   assign req_ready   = (r_state == IDLE);
   assign MREQ        = (r_state == BUS);
   assign DAD         = r_addr;
   assign WRITE       = r_write;
   assign SIZE        = r_size;
   assign resp_valid  = r_resp_valid;
   assign resp_rdata  = r_resp_rdata;
   assign o_dbg_state = r_state;

   // The bus is released the same edge the ack moves the FSM out of BUS.
   assign DDT = ((r_state == BUS) && r_write) ? r_wdata : {DATA_W{1'bz}};

endmodule

// File: tb/tb_data_mem_if.sv
// Directed self-checking bench for data_mem_if with a simple bus memory model.
module tb_data_mem_if;
   import mem_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        misalign;
   logic [31:0] DAD;
   wire  [31:0] DDT;
   logic        MREQ;
   logic        WRITE;
   logic [1:0]  SIZE;
   logic        ACKD_n;
   mem_state_e  dbg_state;

   logic [31:0] mem_data;
   int          n_checks = 0;
   int          n_fail   = 0;

   always #5 clk = ~clk;

   // Memory model returns mem_data on loads only.
   assign DDT = (MREQ && !WRITE) ? mem_data : 32'hzzzz_zzzz;

   data_mem_if dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .misalign     (misalign),
      .DAD          (DAD),
      .DDT          (DDT),
      .MREQ         (MREQ),
      .WRITE        (WRITE),
      .SIZE         (SIZE),
      .ACKD_n       (ACKD_n),
      .o_dbg_state  (dbg_state)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ddt_released();
      return {31'b0, (DDT === 32'hzzzz_zzzz) || (DDT === 32'h0)};
   endfunction

   // Presents one request for a single edge; the unit must be in IDLE.
   task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd);
      req_valid    = 1'b1;
      req_write    = wr;
      req_size     = sz;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wd;
      tick();
      req_valid    = 1'b0;
   endtask

   task automatic load_check(input string tag, input logic [1:0] sz, input logic uns,
                             input logic [31:0] mem, input logic [31:0] exp);
      mem_data = mem;
      ACKD_n   = 1'b0;
      issue(1'b0, sz, uns, 32'h0000_0040, 32'h0);
      check({tag, "_mreq"}, {31'b0, MREQ}, 32'd1);
      tick();
      check({tag, "_valid"}, {31'b0, resp_valid}, 32'd1);
      check({tag, "_rdata"}, resp_rdata, exp);
      tick();
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
      req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; ACKD_n = 1'b1;
      mem_data = '0;
      tick(); tick();
      rst = 1'b0;

      check("rst_mreq",   {31'b0, MREQ},       32'd0);
      check("rst_write",  {31'b0, WRITE},      32'd0);
      check("rst_size",   {30'b0, SIZE},       32'd0);
      check("rst_dad",    DAD,                 32'd0);
      check("rst_valid",  {31'b0, resp_valid}, 32'd0);
      check("rst_rdata",  resp_rdata,          32'd0);
      check("rst_misal",  {31'b0, misalign},   32'd0);
      check("rst_ready",  {31'b0, req_ready},  32'd1);
      check("rst_state",  {30'b0, dbg_state},  32'd0);
      check("rst_ddt_z",  ddt_released(),      32'd1);

      // Ack while idle must not produce anything.
      ACKD_n = 1'b0;
      tick();
      check("idle_ack_valid", {31'b0, resp_valid}, 32'd0);
      check("idle_ack_mreq",  {31'b0, MREQ},       32'd0);

      // Word load, zero wait states, then back-to-back request.
      mem_data = 32'h1234_5678;
      issue(1'b0, SIZE_WORD, 1'b0, 32'h0800_0000, 32'h0);
      check("wl_mreq",  {31'b0, MREQ},       32'd1);
      check("wl_write", {31'b0, WRITE},      32'd0);
      check("wl_size",  {30'b0, SIZE},       32'd0);
      check("wl_dad",   DAD,                 32'h0800_0000);
      check("wl_ready", {31'b0, req_ready},  32'd0);
      check("wl_nvld",  {31'b0, resp_valid}, 32'd0);
      tick();
      check("wl_valid", {31'b0, resp_valid}, 32'd1);
      check("wl_rdata", resp_rdata,          32'h1234_5678);
      check("wl_idle",  {31'b0, MREQ},       32'd0);
      check("wl_rdy2",  {31'b0, req_ready},  32'd1);
      mem_data = 32'hA5A5_0F0F;
      issue(1'b0, SIZE_WORD, 1'b0, 32'h0800_0004, 32'h0);
      check("b2b_mreq",  {31'b0, MREQ},       32'd1);
      check("b2b_pulse", {31'b0, resp_valid}, 32'd0);
      tick();
      check("b2b_rdata", resp_rdata,          32'hA5A5_0F0F);
      tick();

      load_check("sb",  SIZE_BYTE, 1'b0, 32'h1234_5680, 32'hFFFF_FF80);
      load_check("ub",  SIZE_BYTE, 1'b1, 32'h1234_5680, 32'h0000_0080);
      load_check("sh",  SIZE_HALF, 1'b0, 32'hABCD_8001, 32'hFFFF_8001);
      load_check("uh",  SIZE_HALF, 1'b1, 32'hABCD_8001, 32'h0000_8001);
      load_check("sb11", 2'b11,    1'b0, 32'hFFFF_FF7F, 32'h0000_007F);

      // Byte store.
      ACKD_n = 1'b0;
      issue(1'b1, SIZE_BYTE, 1'b0, 32'hF000_0000, 32'hDEAD_BE41);
      check("bs_ddt",   DDT,             32'h0000_0041);
      check("bs_size",  {30'b0, SIZE},   32'd2);
      check("bs_write", {31'b0, WRITE},  32'd1);
      check("bs_dad",   DAD,             32'hF000_0000);
      tick();
      check("bs_valid", {31'b0, resp_valid}, 32'd1);
      check("bs_rdata", resp_rdata,          32'd0);
      check("bs_ddt_z", ddt_released(),      32'd1);
      tick();

      // Size 11 store shows up on the bus as 11 with byte data.
      issue(1'b1, 2'b11, 1'b0, 32'h0000_0010, 32'h1234_56C3);
      check("s11_size", {30'b0, SIZE}, 32'd3);
      check("s11_ddt",  DDT,           32'h0000_00C3);
      tick(); tick();

      // Half store data.
      issue(1'b1, SIZE_HALF, 1'b0, 32'h0000_0020, 32'h1234_BEEF);
      check("hs_ddt", DDT, 32'h0000_BEEF);
      tick(); tick();

      // Word store with three wait states.
      ACKD_n = 1'b1;
      issue(1'b1, SIZE_WORD, 1'b0, 32'h0000_0100, 32'hCAFE_F00D);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("ws_mreq%0d", i),  {31'b0, MREQ},       32'd1);
         check($sformatf("ws_dad%0d", i),   DAD,                 32'h0000_0100);
         check($sformatf("ws_ddt%0d", i),   DDT,                 32'hCAFE_F00D);
         check($sformatf("ws_rdy%0d", i),   {31'b0, req_ready},  32'd0);
         check($sformatf("ws_nvld%0d", i),  {31'b0, resp_valid}, 32'd0);
         if (i == 3) ACKD_n = 1'b0;
         tick();
      end
      check("ws_valid", {31'b0, resp_valid}, 32'd1);
      check("ws_rdata", resp_rdata,          32'd0);
      check("ws_ddt_z", ddt_released(),      32'd1);
      tick();
      check("ws_once",  {31'b0, resp_valid}, 32'd0);

      // Reset in the middle of a bus cycle.
      ACKD_n   = 1'b1;
      mem_data = 32'h0BAD_0BAD;
      issue(1'b0, SIZE_WORD, 1'b0, 32'h0000_0200, 32'h0);
      tick();
      check("rb_mreq", {31'b0, MREQ}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rb_mreq0", {31'b0, MREQ},       32'd0);
      check("rb_ready", {31'b0, req_ready},  32'd1);
      check("rb_nvld",  {31'b0, resp_valid}, 32'd0);
      ACKD_n = 1'b0;
      tick();
      check("rb_nvld2", {31'b0, resp_valid}, 32'd0);
      load_check("rb_next", SIZE_WORD, 1'b0, 32'h600D_600D, 32'h600D_600D);

      // Misaligned word load.
      ACKD_n   = 1'b0;
      mem_data = 32'h55AA_55AA;
      issue(1'b0, SIZE_WORD, 1'b0, 32'h0800_0002, 32'h0);
`ifdef MEM_MISALIGN_TRAP_EN
      check("ma_mreq",  {31'b0, MREQ},       32'd0);
      check("ma_state", {30'b0, dbg_state},  32'd2);
      tick();
      check("ma_mreq2", {31'b0, MREQ},       32'd0);
      check("ma_valid", {31'b0, resp_valid}, 32'd1);
      check("ma_flag",  {31'b0, misalign},   32'd1);
      check("ma_rdata", resp_rdata,          32'd0);
      tick();
      load_check("ma_next", SIZE_WORD, 1'b0, 32'h0000_1111, 32'h0000_1111);
      check("ma_clear", {31'b0, misalign}, 32'd0);
`else
      check("ma_mreq",  {31'b0, MREQ},       32'd1);
      check("ma_dad",   DAD,                 32'h0800_0002);
      tick();
      check("ma_valid", {31'b0, resp_valid}, 32'd1);
      check("ma_flag",  {31'b0, misalign},   32'd0);
      check("ma_rdata", resp_rdata,          32'h55AA_55AA);
      tick();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
